// File: rtl/atm_pkg.sv
// -----------------------------------------------------------------------------
// atm_pkg
//   Shared definitions for the ATM keypad front end: operation codes, special
//   key codes, the entry FSM state encoding and a small key-classification
//   helper. Imported by atm_digit_accum and atm_keypad_entry.
// -----------------------------------------------------------------------------
package atm_pkg;

  // Operation codes understood by the ATM transaction core
  localparam logic [2:0] OP_BAL   = 3'd3;
  localparam logic [2:0] OP_WDR   = 3'd4;
  localparam logic [2:0] OP_DEP   = 3'd5;
  localparam logic [2:0] OP_CHPIN = 3'd6;

  // Non-digit keypad codes; D-F are deliberately left undefined (ignored keys)
  localparam logic [3:0] KEY_ENTER  = 4'hA;
  localparam logic [3:0] KEY_CLEAR  = 4'hB;
  localparam logic [3:0] KEY_CANCEL = 4'hC;

  // Entry FSM states; the encoding is visible on fsm_state for display/debug
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_OP     = 3'd1,
    ST_ACC    = 3'd2,
    ST_PIN    = 3'd3,
    ST_AMT    = 3'd4,
    ST_NEWPIN = 3'd5,
    ST_REQ    = 3'd6
  } state_t;

  // True for decimal digit keys 0-9
  function automatic logic is_digit(input logic [3:0] key);
    return (key <= 4'd9);
  endfunction

endpackage

// File: rtl/atm_digit_accum.sv
// -----------------------------------------------------------------------------
// atm_digit_accum
//   Decimal accumulator shared by all numeric fields. Each accepted digit
//   performs value = value*10 + digit at 32 bits and bumps the digit counter.
//   The per-field digit limit arrives at run time on 'limit'; MAX_DIGITS is an
//   absolute ceiling that keeps the 32-bit value from wrapping.
// Ports
//   clk    in   1   system clock, rising edge
//   rst    in   1   asynchronous active-high reset
//   clear  in   1   zero value and counter (has priority over load)
//   load   in   1   append 'digit' when not full
//   digit  in   4   decimal digit 0-9
//   limit  in   4   digit limit for the field currently being entered
//   value  out  32  accumulated binary value
//   count  out  4   number of digits accepted
//   full   out  1   no further digit may be appended
// -----------------------------------------------------------------------------
module atm_digit_accum
  import atm_pkg::*;
#(
  parameter int MAX_DIGITS = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        load,
  input  logic [3:0]  digit,
  input  logic [3:0]  limit,
  output logic [31:0] value,
  output logic [3:0]  count,
  output logic        full
);

  localparam logic [3:0] CEILING = 4'(MAX_DIGITS);

  assign full = (count >= limit) || (count >= CEILING);

  // Value and digit-count registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= 32'd0;
      count <= 4'd0;
    end else if (clear) begin
      value <= 32'd0;
      count <= 4'd0;
    end else if (load && !full) begin
      value <= (value * 32'd10) + {28'd0, digit};
      count <= count + 4'd1;
    end else begin
      value <= value;
      count <= count;
    end
  end

endmodule

// File: rtl/atm_keypad_entry.sv
// -----------------------------------------------------------------------------
// atm_keypad_entry
//   Keypad front end for the ATM transaction core. Collects keypad codes,
//   assembles language, operation, account, PIN, amount and new PIN, then
//   issues one request per session on a valid/ready handshake.
// Ports
//   clk        in   1   system clock, rising edge
//   rst        in   1   asynchronous active-high reset
//   key_valid  in   1   key_code valid this cycle
//   key_code   in   4   0-9 digit, A=ENTER, B=CLEAR, C=CANCEL, D-F ignored
//   req_valid  out  1   request valid, held until req_ready
//   req_ready  in   1   ATM core accepts request
//   operation  out  3   3 balance, 4 withdraw, 5 deposit, 6 change PIN
//   acc_num    out  4   account number
//   pin        out  16  entered PIN
//   amount     out  32  amount (0 for balance / change PIN)
//   new_pin    out  16  new PIN (0 unless change PIN)
//   language   out  1   language select
//   entry_err  out  1   pulse: invalid key or ENTER rejected
//   abort      out  1   pulse: session cancelled or timed out
//   fsm_state  out  3   current state encoding
// -----------------------------------------------------------------------------
module atm_keypad_entry
  import atm_pkg::*;
#(
  parameter int ACC_DIGITS  = 2,
  parameter int AMT_DIGITS  = 7,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [2:0]  operation,
  output logic [3:0]  acc_num,
  output logic [15:0] pin,
  output logic [31:0] amount,
  output logic [15:0] new_pin,
  output logic        language,
  output logic        entry_err,
  output logic        abort,
  output logic [2:0]  fsm_state
);

  localparam int          TW        = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [3:0]  ACC_LIMIT = 4'(ACC_DIGITS);
  localparam logic [3:0]  AMT_LIMIT = 4'(AMT_DIGITS);
  localparam logic [3:0]  PIN_LIMIT = 4'd4;

  state_t        state_r;
  state_t        next_s;
  logic [TW-1:0] timer_r;

  logic          counting_s;
  logic          timeout_s;
  logic          err_s;
  logic          abort_s;
  logic          clear_all_s;
  logic          acc_clear_s;
  logic          acc_load_s;
  logic [3:0]    acc_limit_s;
  logic          enter_ok_s;
  logic          set_lang_s;
  logic          set_op_s;
  logic          cap_acc_s;
  logic          cap_pin_s;
  logic          cap_amt_s;
  logic          cap_newpin_s;

  logic [31:0]   acc_value_s;
  logic [3:0]    acc_count_s;
  logic          acc_full_s;

  atm_digit_accum #(
    .MAX_DIGITS (AMT_DIGITS)
  ) u_accum (
    .clk   (clk),
    .rst   (rst),
    .clear (acc_clear_s | clear_all_s),
    .load  (acc_load_s),
    .digit (key_code),
    .limit (acc_limit_s),
    .value (acc_value_s),
    .count (acc_count_s),
    .full  (acc_full_s)
  );

  assign fsm_state = state_r;

  // The idle timer only runs while a session is being typed in; a key this
  // cycle restarts it, so a key arriving on the last cycle wins over timeout.
  assign counting_s = (state_r != ST_IDLE) && (state_r != ST_REQ);
  assign timeout_s  = counting_s && !key_valid && (timer_r == TO_LAST);

  // Next-state, key decoding and register-enable generation
  always_comb begin
    next_s       = state_r;
    err_s        = 1'b0;
    abort_s      = 1'b0;
    clear_all_s  = 1'b0;
    acc_clear_s  = 1'b0;
    acc_load_s   = 1'b0;
    acc_limit_s  = 4'd0;
    enter_ok_s   = 1'b0;
    set_lang_s   = 1'b0;
    set_op_s     = 1'b0;
    cap_acc_s    = 1'b0;
    cap_pin_s    = 1'b0;
    cap_amt_s    = 1'b0;
    cap_newpin_s = 1'b0;

    // Digit limit and ENTER acceptance rule of the field being entered
    case (state_r)
      ST_ACC: begin
        acc_limit_s = ACC_LIMIT;
        enter_ok_s  = (acc_count_s != 4'd0) && (acc_value_s != 32'd0) &&
                      (acc_value_s <= 32'd15);
      end
      ST_PIN, ST_NEWPIN: begin
        acc_limit_s = PIN_LIMIT;
        enter_ok_s  = (acc_count_s == PIN_LIMIT);
      end
      ST_AMT: begin
        acc_limit_s = AMT_LIMIT;
        enter_ok_s  = (acc_value_s != 32'd0);
      end
      default: begin
        acc_limit_s = 4'd0;
        enter_ok_s  = 1'b0;
      end
    endcase

    case (state_r)
      ST_IDLE: begin
        if (key_valid && (key_code <= 4'd1)) begin
          set_lang_s = 1'b1;
          next_s     = ST_OP;
        end else if (key_valid && (key_code <= KEY_CANCEL)) begin
          err_s = 1'b1;
        end else begin
          next_s = ST_IDLE;
        end
      end

      ST_OP: begin
        if (timeout_s || (key_valid && (key_code == KEY_CANCEL))) begin
          abort_s     = 1'b1;
          clear_all_s = 1'b1;
          next_s      = ST_IDLE;
        end else if (key_valid && (key_code >= OP_BAL) && (key_code <= 4'(OP_CHPIN))) begin
          set_op_s = 1'b1;
          next_s   = ST_ACC;
        end else if (key_valid && (is_digit(key_code) || (key_code == KEY_ENTER))) begin
          err_s = 1'b1;
        end else begin
          next_s = ST_OP;
        end
      end

      ST_ACC, ST_PIN, ST_AMT, ST_NEWPIN: begin
        if (timeout_s || (key_valid && (key_code == KEY_CANCEL))) begin
          abort_s     = 1'b1;
          clear_all_s = 1'b1;
          next_s      = ST_IDLE;
        end else if (key_valid && is_digit(key_code)) begin
          // A digit beyond the field width is dropped rather than overflowing
          if (acc_full_s) begin
            err_s = 1'b1;
          end else begin
            acc_load_s = 1'b1;
          end
        end else if (key_valid && (key_code == KEY_CLEAR)) begin
          acc_clear_s = 1'b1;
        end else if (key_valid && (key_code == KEY_ENTER)) begin
          if (enter_ok_s) begin
            acc_clear_s = 1'b1;
            case (state_r)
              ST_ACC: begin
                cap_acc_s = 1'b1;
                next_s    = ST_PIN;
              end
              ST_PIN: begin
                cap_pin_s = 1'b1;
                if (operation == OP_BAL) begin
                  next_s = ST_REQ;
                end else if (operation == OP_CHPIN) begin
                  next_s = ST_NEWPIN;
                end else begin
                  next_s = ST_AMT;
                end
              end
              ST_AMT: begin
                cap_amt_s = 1'b1;
                next_s    = ST_REQ;
              end
              default: begin
                cap_newpin_s = 1'b1;
                next_s       = ST_REQ;
              end
            endcase
          end else begin
            err_s = 1'b1;
          end
        end else begin
          next_s = state_r;
        end
      end

      // Request is committed: keys (even CANCEL) are ignored until accepted
      ST_REQ: begin
        if (req_ready) begin
          clear_all_s = 1'b1;
          next_s      = ST_IDLE;
        end else begin
          next_s = ST_REQ;
        end
      end

      default: begin
        clear_all_s = 1'b1;
        next_s      = ST_IDLE;
      end
    endcase
  end

  // State register, idle timer, status pulses and session field registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      timer_r   <= '0;
      req_valid <= 1'b0;
      entry_err <= 1'b0;
      abort     <= 1'b0;
      operation <= 3'd0;
      acc_num   <= 4'd0;
      pin       <= 16'd0;
      amount    <= 32'd0;
      new_pin   <= 16'd0;
      language  <= 1'b0;
    end else begin
      state_r   <= next_s;
      req_valid <= (next_s == ST_REQ);
      entry_err <= err_s;
      abort     <= abort_s;

      if (key_valid || !counting_s || clear_all_s) begin
        timer_r <= '0;
      end else begin
        timer_r <= timer_r + TW'(1);
      end

      if (clear_all_s) begin
        operation <= 3'd0;
        acc_num   <= 4'd0;
        pin       <= 16'd0;
        amount    <= 32'd0;
        new_pin   <= 16'd0;
        language  <= 1'b0;
      end else begin
        if (set_lang_s)   language  <= key_code[0];
        if (set_op_s)     operation <= key_code[2:0];
        if (cap_acc_s)    acc_num   <= acc_value_s[3:0];
        if (cap_pin_s)    pin       <= acc_value_s[15:0];
        if (cap_amt_s)    amount    <= acc_value_s;
        if (cap_newpin_s) new_pin   <= acc_value_s[15:0];
      end
    end
  end

endmodule

// File: tb/tb_atm_keypad_entry.sv
// -----------------------------------------------------------------------------
// tb_atm_keypad_entry
//   Self-checking bench for atm_keypad_entry: a key/expected-state table for a
//   balance session with rejected entries, then hand-written sequences for
//   deposit, change PIN with a stalled core, cancel, timeout and reset.
// -----------------------------------------------------------------------------
module tb_atm_keypad_entry;

  logic        clk;
  logic        rst;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  operation;
  logic [3:0]  acc_num;
  logic [15:0] pin;
  logic [31:0] amount;
  logic [15:0] new_pin;
  logic        language;
  logic        entry_err;
  logic        abort;
  logic [2:0]  fsm_state;

  int n_checks = 0;
  int n_fail   = 0;

  atm_keypad_entry #(
    .ACC_DIGITS  (2),
    .AMT_DIGITS  (7),
    .TIMEOUT_CYC (20)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_code  (key_code),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .operation (operation),
    .acc_num   (acc_num),
    .pin       (pin),
    .amount    (amount),
    .new_pin   (new_pin),
    .language  (language),
    .entry_err (entry_err),
    .abort     (abort),
    .fsm_state (fsm_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] key;
    logic [2:0] st;
    logic       err;
  } vec_t;

  localparam int NV = 18;
  vec_t tbl [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One-cycle key strobe; returns at the negedge after the sampling edge
  task automatic press(input logic [3:0] k);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = k;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'hF;
  endtask

  task automatic accept_req();
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    chk("accept_state", 32'(fsm_state), 32'd0);
    chk("accept_req_valid", 32'(req_valid), 32'd0);
    chk("accept_op_cleared", 32'(operation), 32'd0);
    chk("accept_pin_cleared", 32'(pin), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{4'h5, 3'd0, 1'b1};  // IDLE: non-language digit
    tbl[1]  = '{4'hE, 3'd0, 1'b0};  // ignored key
    tbl[2]  = '{4'h0, 3'd1, 1'b0};  // language 0
    tbl[3]  = '{4'h8, 3'd1, 1'b1};  // bad operation
    tbl[4]  = '{4'h3, 3'd2, 1'b0};  // balance
    tbl[5]  = '{4'hA, 3'd2, 1'b1};  // ENTER with no digits
    tbl[6]  = '{4'h0, 3'd2, 1'b0};
    tbl[7]  = '{4'hA, 3'd2, 1'b1};  // account 0 rejected
    tbl[8]  = '{4'hB, 3'd2, 1'b0};  // CLEAR
    tbl[9]  = '{4'h1, 3'd2, 1'b0};
    tbl[10] = '{4'hA, 3'd3, 1'b0};  // account 1 accepted
    tbl[11] = '{4'h1, 3'd3, 1'b0};
    tbl[12] = '{4'h2, 3'd3, 1'b0};
    tbl[13] = '{4'h3, 3'd3, 1'b0};
    tbl[14] = '{4'hA, 3'd3, 1'b1};  // 3-digit PIN rejected
    tbl[15] = '{4'h4, 3'd3, 1'b0};
    tbl[16] = '{4'h5, 3'd3, 1'b1};  // 5th PIN digit dropped
    tbl[17] = '{4'hA, 3'd6, 1'b0};  // balance goes straight to REQ

    rst       = 1'b1;
    key_valid = 1'b0;
    key_code  = 4'hF;
    req_ready = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_state", 32'(fsm_state), 32'd0);
    chk("rst_req_valid", 32'(req_valid), 32'd0);
    chk("rst_operation", 32'(operation), 32'd0);
    chk("rst_pin", 32'(pin), 32'd0);
    chk("rst_amount", amount, 32'd0);
    chk("rst_entry_err", 32'(entry_err), 32'd0);
    chk("rst_abort", 32'(abort), 32'd0);
    rst = 1'b0;

    // Balance session with rejected entries along the way
    for (int i = 0; i < NV; i++) begin
      press(tbl[i].key);
      chk($sformatf("tbl%0d_state", i), 32'(fsm_state), 32'(tbl[i].st));
      chk($sformatf("tbl%0d_err", i), 32'(entry_err), 32'(tbl[i].err));
    end
    chk("bal_req_valid", 32'(req_valid), 32'd1);
    chk("bal_op", 32'(operation), 32'd3);
    chk("bal_acc", 32'(acc_num), 32'd1);
    chk("bal_pin", 32'(pin), 32'd1234);
    chk("bal_amount", amount, 32'd0);
    chk("bal_new_pin", 32'(new_pin), 32'd0);
    chk("bal_lang", 32'(language), 32'd0);
    press(4'hC);  // CANCEL in REQ is ignored
    chk("req_cancel_state", 32'(fsm_state), 32'd6);
    chk("req_cancel_abort", 32'(abort), 32'd0);
    chk("req_cancel_valid", 32'(req_valid), 32'd1);
    accept_req();

    // Deposit, with a CLEAR inside the PIN and a rejected zero amount
    press(4'h1); press(4'h5); press(4'h1); press(4'h0); press(4'hA);
    press(4'h7); press(4'h1); press(4'h2); press(4'hB);
    press(4'h7); press(4'h1); press(4'h2); press(4'h3); press(4'hA);
    chk("dep_state_amt", 32'(fsm_state), 32'd4);
    press(4'hA);
    chk("dep_zero_amt_err", 32'(entry_err), 32'd1);
    press(4'h1); press(4'h0); press(4'h0); press(4'h0); press(4'hA);
    chk("dep_req_valid", 32'(req_valid), 32'd1);
    chk("dep_op", 32'(operation), 32'd5);
    chk("dep_acc", 32'(acc_num), 32'd10);
    chk("dep_pin", 32'(pin), 32'd7123);
    chk("dep_amount", amount, 32'd1000);
    chk("dep_lang", 32'(language), 32'd1);
    accept_req();

    // Change PIN, core stalls for 5 cycles, then reset while request is pending
    press(4'h0); press(4'h6); press(4'h2); press(4'hA);
    press(4'h2); press(4'h3); press(4'h4); press(4'h5); press(4'hA);
    chk("chp_state_newpin", 32'(fsm_state), 32'd5);
    press(4'h6); press(4'h7); press(4'h8); press(4'h9); press(4'hA);
    chk("chp_op", 32'(operation), 32'd6);
    chk("chp_acc", 32'(acc_num), 32'd2);
    chk("chp_pin", 32'(pin), 32'd2345);
    chk("chp_amount", amount, 32'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("chp_hold%0d_valid", c), 32'(req_valid), 32'd1);
      chk($sformatf("chp_hold%0d_new_pin", c), 32'(new_pin), 32'd6789);
    end
    rst = 1'b1;
    #1;
    chk("midreq_rst_valid", 32'(req_valid), 32'd0);
    chk("midreq_rst_state", 32'(fsm_state), 32'd0);
    chk("midreq_rst_new_pin", 32'(new_pin), 32'd0);
    chk("midreq_rst_op", 32'(operation), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // CANCEL while entering the amount
    press(4'h1); press(4'h4); press(4'h5); press(4'hA);
    press(4'h1); press(4'h1); press(4'h1); press(4'h1); press(4'hA);
    press(4'h9);
    chk("cxl_state_amt", 32'(fsm_state), 32'd4);
    press(4'hC);
    chk("cxl_abort", 32'(abort), 32'd1);
    chk("cxl_state", 32'(fsm_state), 32'd0);
    chk("cxl_lang", 32'(language), 32'd0);
    chk("cxl_acc", 32'(acc_num), 32'd0);
    chk("cxl_pin", 32'(pin), 32'd0);
    @(negedge clk);
    chk("cxl_abort_pulse", 32'(abort), 32'd0);

    // Idle timeout in PIN: 20 cycles with no keys
    press(4'h0); press(4'h3); press(4'h1); press(4'hA);
    repeat (19) @(negedge clk);
    chk("to_before_state", 32'(fsm_state), 32'd3);
    chk("to_before_abort", 32'(abort), 32'd0);
    @(negedge clk);
    chk("to_abort", 32'(abort), 32'd1);
    chk("to_state", 32'(fsm_state), 32'd0);
    begin
      int extra = 0;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        if (abort) extra++;
      end
      chk("to_single_pulse", 32'(extra), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
